// File: rtl/xf_vertex_sequencer.sv
// xf_vertex_sequencer
//   Streams model-space vertices through the matrix DSP position-transform
//   stage. Each accepted vertex gets one DSP start pulse, the sequencer waits
//   for the DSP result (bounded by a timeout), and captures the transformed
//   x,y,z into a small first-word-fall-through FIFO for the setup stage.
//   Only one vertex is in flight at a time.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   cfg_address/write/
//   cfg_writedata              matrix lane writes (0-11), error clear (15)
//   cfg_waitrequest            stalls matrix writes while an operation runs
//   vtx_valid/ready/data       input vertex stream {x, y, z}
//   dsp_cycle, dsp_ready       DSP start pulse / result valid
//   dsp_input_vector           {x, y, z, 1.0f}
//   dsp_row_a/b/c              matrix rows, lane 0 in the top word
//   dsp_output_vector          DSP result, x,y,z in [127:32]
//   out_valid/ready/data       output FIFO head {x, y, z}
//   busy, err_timeout          operation in progress / sticky DSP timeout
module xf_vertex_sequencer #(
  parameter int unsigned OUT_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   cfg_address,
  input  logic         cfg_write,
  input  logic [31:0]  cfg_writedata,
  output logic         cfg_waitrequest,
  input  logic         vtx_valid,
  output logic         vtx_ready,
  input  logic [95:0]  vtx_data,
  output logic         dsp_cycle,
  input  logic         dsp_ready,
  output logic [127:0] dsp_input_vector,
  output logic [127:0] dsp_row_a,
  output logic [127:0] dsp_row_b,
  output logic [127:0] dsp_row_c,
  input  logic [127:0] dsp_output_vector,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [95:0]  out_data,
  output logic         busy,
  output logic         err_timeout
);

  localparam int unsigned PW = $clog2(OUT_DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [31:0] ONE_F = 32'h3F800000;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE} state_t;

  state_t state, state_nx;

  logic [31:0]   mat [12];
  logic [95:0]   in_reg;
  logic [CW-1:0] wait_cnt;

  logic [95:0]   fifo_mem [OUT_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  logic cfg_hit, cfg_apply, fifo_full, push, pop, timeout_hit, accept;

  assign cfg_hit         = cfg_write && (cfg_address < 4'd12);
  assign cfg_waitrequest = cfg_hit && (state != S_IDLE);
  assign cfg_apply       = cfg_hit && (state == S_IDLE);

  assign fifo_full = (count == (PW + 1)'(OUT_DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = fifo_mem[rd_ptr];
  assign pop       = out_ready && out_valid;
  assign accept    = vtx_valid && vtx_ready;

  assign busy             = (state != S_IDLE);
  assign dsp_input_vector = {in_reg, ONE_F};
  assign dsp_row_a        = {mat[0], mat[1], mat[2],  mat[3]};
  assign dsp_row_b        = {mat[4], mat[5], mat[6],  mat[7]};
  assign dsp_row_c        = {mat[8], mat[9], mat[10], mat[11]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    dsp_cycle   = 1'b0;
    vtx_ready   = 1'b0;
    push        = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        // A matrix write landing this cycle blocks acceptance so the rows
        // seen by the DSP never change under a started operation.
        vtx_ready = !reset && !fifo_full && !cfg_apply;
        if (vtx_valid && vtx_ready) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        dsp_cycle = 1'b1;
        state_nx  = S_WAIT;
      end
      S_WAIT: begin
        // dsp_ready is still stale-high during the first WAIT cycle.
        if (wait_cnt != '0 && dsp_ready) begin
          state_nx = S_STORE;
        end else if (wait_cnt == LAST_WAIT) begin
          timeout_hit = 1'b1;
          state_nx    = S_IDLE;
        end
      end
      S_STORE: begin
        push     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_reg   <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == S_IDLE && accept) in_reg <= vtx_data;
      if (state == S_ISSUE)      wait_cnt <= '0;
      else if (state == S_WAIT)  wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 12; i++)
        mat[i] <= (i == 0 || i == 5 || i == 10) ? ONE_F : '0;
      err_timeout <= 1'b0;
    end else begin
      if (cfg_apply) mat[cfg_address] <= cfg_writedata;
      if (timeout_hit)                            err_timeout <= 1'b1;
      else if (cfg_write && cfg_address == 4'hF)  err_timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= dsp_output_vector[127:32];
  end

endmodule

// File: tb/tb_xf_vertex_sequencer.sv
// Testbench for xf_vertex_sequencer: DSP behavioural model plus a queue-based
// reference of the expected output stream.
module tb_xf_vertex_sequencer;

  logic         clk;
  logic         reset;
  logic [3:0]   cfg_address;
  logic         cfg_write;
  logic [31:0]  cfg_writedata;
  logic         cfg_waitrequest;
  logic         vtx_valid;
  logic         vtx_ready;
  logic [95:0]  vtx_data;
  logic         dsp_cycle;
  logic         dsp_ready;
  logic [127:0] dsp_input_vector;
  logic [127:0] dsp_row_a, dsp_row_b, dsp_row_c;
  logic [127:0] dsp_output_vector;
  logic         out_valid;
  logic         out_ready;
  logic [95:0]  out_data;
  logic         busy;
  logic         err_timeout;

  localparam logic [383:0] ID_ROWS = {32'h3F800000, 96'h0,
                                      32'h0, 32'h3F800000, 64'h0,
                                      64'h0, 32'h3F800000, 32'h0};

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_pop = 0;
  int n_pulse = 0;
  logic [95:0] exp_q[$];
  logic [31:0] shadow [12];

  xf_vertex_sequencer #(.OUT_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .cfg_address(cfg_address), .cfg_write(cfg_write), .cfg_writedata(cfg_writedata),
    .cfg_waitrequest(cfg_waitrequest),
    .vtx_valid(vtx_valid), .vtx_ready(vtx_ready), .vtx_data(vtx_data),
    .dsp_cycle(dsp_cycle), .dsp_ready(dsp_ready), .dsp_input_vector(dsp_input_vector),
    .dsp_row_a(dsp_row_a), .dsp_row_b(dsp_row_b), .dsp_row_c(dsp_row_c),
    .dsp_output_vector(dsp_output_vector),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DSP model: ready stays stale-high through the first cycle after the start
  // pulse, then drops; the result (x,y,z each XORed with lane 3 of its row) is
  // presented with ready dsp_lat cycles later. It ignores reset on purpose.
  int          dsp_lat = 2;
  bit          dsp_hang = 0;
  int          dsp_phase = 0;
  int          dsp_cnt = 0;
  bit          dsp_raised = 0;
  logic [127:0] dsp_result = '0;
  initial begin
    dsp_ready = 1'b1;
    dsp_output_vector = '0;
  end
  always @(posedge clk) begin
    dsp_raised <= 1'b0;
    if (dsp_cycle) begin
      dsp_phase  <= 1;
      dsp_cnt    <= dsp_lat;
      dsp_result <= {dsp_input_vector[127:96] ^ dsp_row_a[31:0],
                     dsp_input_vector[95:64]  ^ dsp_row_b[31:0],
                     dsp_input_vector[63:32]  ^ dsp_row_c[31:0],
                     dsp_input_vector[31:0]};
    end else if (dsp_phase == 1) begin
      dsp_ready <= 1'b0;
      dsp_phase <= 2;
    end else if (dsp_phase == 2) begin
      if (dsp_cnt > 1) dsp_cnt <= dsp_cnt - 1;
      else if (!dsp_hang) begin
        dsp_ready         <= 1'b1;
        dsp_output_vector <= dsp_result;
        dsp_phase         <= 0;
        dsp_raised        <= 1'b1;
      end
    end
  end

  function automatic logic [95:0] model_out(input logic [95:0] v);
    return {v[95:64] ^ shadow[3], v[63:32] ^ shadow[7], v[31:0] ^ shadow[11]};
  endfunction

  // Reference stream: every accepted vertex must come out once, in order.
  always @(negedge clk) begin
    if (!reset) begin
      if (dsp_cycle) n_pulse++;
      if (vtx_valid && vtx_ready) begin
        exp_q.push_back(model_out(vtx_data));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_pop++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected got=%h want=<none>", out_data);
        end else begin
          logic [95:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            bad++;
            $display("FAIL pop_data got=%h want=%h", out_data, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_shadow();
    for (int i = 0; i < 12; i++) shadow[i] = (i == 0 || i == 5 || i == 10) ? 32'h3F800000 : 32'h0;
  endtask

  task automatic send(input logic [95:0] d, input int budget, output bit ok);
    vtx_data  = d;
    vtx_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (vtx_ready) ok = 1;
      tick();
    end
    vtx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    total++;
    if (busy) begin bad++; $display("FAIL wait_idle busy=%b want=0", busy); end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    out_ready = 1'b1;
    while ((busy || out_valid) && n < budget) begin tick(); n++; end
    out_ready = 1'b0;
    total++;
    if (busy || out_valid || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain busy=%b out_valid=%b pending=%0d want=0/0/0", busy, out_valid, exp_q.size());
    end
  endtask

  task automatic cfg(input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    cfg_address = a; cfg_writedata = d; cfg_write = 1'b1;
    #1;
    while (cfg_waitrequest && n < 200) begin tick(); n++; end
    total++;
    if (cfg_waitrequest) begin bad++; $display("FAIL cfg_stuck waitrequest=%b want=0", cfg_waitrequest); end
    tick();
    cfg_write = 1'b0;
    if (a < 4'd12) shadow[a] = d;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (vtx_ready !== 1'b0) begin bad++; $display("FAIL reset_vtx_ready got=%b want=0", vtx_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_timeout); end
    total++; if (dsp_cycle !== 1'b0) begin bad++; $display("FAIL reset_dsp_cycle got=%b want=0", dsp_cycle); end
    total++;
    if ({dsp_row_a, dsp_row_b, dsp_row_c} !== ID_ROWS) begin
      bad++; $display("FAIL reset_rows got=%h want=%h", {dsp_row_a, dsp_row_b, dsp_row_c}, ID_ROWS);
    end
    reset = 1'b0;
    #1;
    total++; if (vtx_ready !== 1'b1) begin bad++; $display("FAIL idle_vtx_ready got=%b want=1", vtx_ready); end
    tick();
  endtask

  task automatic test_identity();
    logic [95:0] d;
    bit ok;
    int p0, n;
    d  = {32'h3F800000, 32'h40000000, 32'h40400000};
    out_ready = 1'b0;
    p0 = n_pulse;
    send(d, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL ident_accept got=0 want=1"); end
    total++; if (dsp_cycle !== 1'b1) begin bad++; $display("FAIL ident_pulse got=%b want=1", dsp_cycle); end
    total++;
    if (dsp_input_vector !== {d, 32'h3F800000}) begin
      bad++; $display("FAIL ident_invec got=%h want=%h", dsp_input_vector, {d, 32'h3F800000});
    end
    tick();
    total++; if (dsp_cycle !== 1'b0) begin bad++; $display("FAIL ident_pulse_width got=%b want=0", dsp_cycle); end
    total++;
    if (dsp_input_vector !== {d, 32'h3F800000}) begin
      bad++; $display("FAIL ident_invec_hold got=%h want=%h", dsp_input_vector, {d, 32'h3F800000});
    end
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    total++; if (out_data !== d || !out_valid) begin bad++; $display("FAIL ident_out got=%h want=%h", out_data, d); end
    total++; if (n_pulse - p0 != 1) begin bad++; $display("FAIL ident_pulses got=%0d want=1", n_pulse - p0); end
    drain(50);
  endtask

  task automatic test_cfg_stall();
    bit ok, stall_ok;
    int n;
    logic [3:0] ign;
    dsp_lat = 6;
    out_ready = 1'b1;
    send({$urandom, $urandom, $urandom}, 20, ok);
    tick();
    cfg_address = 4'd3; cfg_writedata = 32'h41200000; cfg_write = 1'b1;
    #1;
    stall_ok = 1; n = 0;
    while (busy && n < 100) begin
      if (cfg_waitrequest !== 1'b1) stall_ok = 0;
      tick(); n++;
    end
    total++; if (!stall_ok || n == 0) begin bad++; $display("FAIL cfg_stall held=%0d cycles=%0d want=1/>0", stall_ok, n); end
    total++; if (cfg_waitrequest !== 1'b0) begin bad++; $display("FAIL cfg_release got=%b want=0", cfg_waitrequest); end
    total++; if (dsp_row_a[31:0] !== 32'h0) begin bad++; $display("FAIL cfg_early got=%h want=0", dsp_row_a[31:0]); end
    tick();
    cfg_write = 1'b0;
    shadow[3] = 32'h41200000;
    total++; if (dsp_row_a[31:0] !== 32'h41200000) begin bad++; $display("FAIL cfg_applied got=%h want=41200000", dsp_row_a[31:0]); end
    ign = 4'(12 + $urandom_range(0, 2));
    cfg(ign, $urandom);
    total++;
    if (dsp_row_a !== {shadow[0], shadow[1], shadow[2], shadow[3]} ||
        dsp_row_b !== {shadow[4], shadow[5], shadow[6], shadow[7]} ||
        dsp_row_c !== {shadow[8], shadow[9], shadow[10], shadow[11]}) begin
      bad++; $display("FAIL cfg_ignored addr=%0d got=%h want=unchanged rows", ign, {dsp_row_a, dsp_row_b, dsp_row_c});
    end
    cfg(4'd7, 32'h00C0FFEE);
    total++; if (dsp_row_b[31:0] !== 32'h00C0FFEE) begin bad++; $display("FAIL cfg_row_b got=%h want=00c0ffee", dsp_row_b[31:0]); end
    drain(50);
  endtask

  task automatic test_backpressure();
    bit ok;
    int a0, accepted;
    dsp_lat = 2;
    out_ready = 1'b0;
    a0 = n_acc; accepted = 0;
    for (int i = 0; i < 6; i++) begin
      send({$urandom, $urandom, $urandom}, 30, ok);
      if (ok) accepted++;
    end
    total++; if (accepted != 4) begin bad++; $display("FAIL bp_accepted got=%0d want=4", accepted); end
    vtx_valid = 1'b1;
    #1;
    total++; if (vtx_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", vtx_ready); end
    vtx_valid = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 3; i++) begin
      send({$urandom, $urandom, $urandom}, 30, ok);
      if (ok) accepted++;
    end
    total++; if (accepted != 2) begin bad++; $display("FAIL bp_refill got=%0d want=2", accepted); end
    total++; if (n_acc - a0 != 6) begin bad++; $display("FAIL bp_total got=%0d want=6", n_acc - a0); end
    drain(100);
  endtask

  task automatic test_push_pop_full();
    bit ok;
    int n, p0;
    out_ready = 1'b0;
    dsp_lat = 3;
    for (int i = 0; i < 3; i++) send({$urandom, $urandom, $urandom}, 30, ok);
    wait_idle(50);
    p0 = n_pop;
    send({$urandom, $urandom, $urandom}, 30, ok);
    n = 0;
    while (!dsp_raised && n < 50) begin tick(); n++; end
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (vtx_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ppf_not_full ready=%b busy=%b want=1/0", vtx_ready, busy); end
    drain(50);
    total++; if (n_pop - p0 != 4) begin bad++; $display("FAIL ppf_pops got=%0d want=4", n_pop - p0); end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [95:0] d0, e0, tmp;
    out_ready = 1'b0;
    dsp_lat = 2;
    d0 = {$urandom, $urandom, $urandom};
    e0 = model_out(d0);
    send(d0, 30, ok);
    wait_idle(50);
    dsp_hang = 1;
    send({$urandom, $urandom, $urandom}, 30, ok);
    repeat (64) tick();
    total++; if (err_timeout !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL to_early err=%b busy=%b want=0/1", err_timeout, busy); end
    tick();
    total++; if (err_timeout !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL to_set err=%b busy=%b want=1/0", err_timeout, busy); end
    tmp = exp_q.pop_back();
    total++; if (out_valid !== 1'b1 || out_data !== e0) begin bad++; $display("FAIL to_fifo got=%h want=%h", out_data, e0); end
    dsp_hang = 0;
    send({$urandom, $urandom, $urandom}, 30, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_next_accept got=0 want=1"); end
    wait_idle(50);
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", err_timeout); end
    send({$urandom, $urandom, $urandom}, 30, ok);
    cfg_address = 4'hF; cfg_writedata = '0; cfg_write = 1'b1;
    #1;
    total++; if (cfg_waitrequest !== 1'b0) begin bad++; $display("FAIL to_clear_stall got=%b want=0", cfg_waitrequest); end
    tick();
    cfg_write = 1'b0;
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_clear got=%b want=0", err_timeout); end
    drain(100);
  endtask

  task automatic test_random();
    bit ok;
    int a0, p0;
    a0 = n_acc; p0 = n_pop;
    for (int i = 0; i < 30; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      dsp_lat = $urandom_range(1, 5);
      if ($urandom_range(0, 3) == 0) cfg(4'($urandom_range(0, 14)), $urandom);
      send({$urandom, $urandom, $urandom}, 30, ok);
    end
    drain(200);
    total++; if (n_acc - a0 != n_pop - p0) begin bad++; $display("FAIL rand_count got=%0d want=%0d", n_pop - p0, n_acc - a0); end
  endtask

  task automatic test_async_reset();
    bit ok, quiet;
    logic [95:0] d;
    out_ready = 1'b0;
    dsp_lat = 8;
    cfg(4'd3, 32'h41200000);
    send({$urandom, $urandom, $urandom}, 30, ok);
    wait_idle(50);
    send({$urandom, $urandom, $urandom}, 30, ok);
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL ar_immediate busy=%b out_valid=%b want=0/0", busy, out_valid); end
    total++;
    if ({dsp_row_a, dsp_row_b, dsp_row_c} !== ID_ROWS) begin
      bad++; $display("FAIL ar_rows got=%h want=%h", {dsp_row_a, dsp_row_b, dsp_row_c}, ID_ROWS);
    end
    exp_q.delete();
    reset_shadow();
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    quiet = 1;
    for (int i = 0; i < 20; i++) begin
      if (busy || out_valid) quiet = 0;
      tick();
    end
    total++; if (!quiet) begin bad++; $display("FAIL ar_late_ready got=active want=idle"); end
    d = {$urandom, $urandom, $urandom};
    send(d, 30, ok);
    drain(100);
    total++; if (!ok) begin bad++; $display("FAIL ar_recover got=0 want=1"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cfg_address = '0; cfg_write = 1'b0; cfg_writedata = '0;
    vtx_valid = 1'b0; vtx_data = '0; out_ready = 1'b0;
    reset_shadow();
    test_reset();
    test_identity();
    test_cfg_stall();
    test_backpressure();
    test_push_pop_full();
    test_timeout();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
